// File: rtl/raspi_gpio_pkg.sv
// Shared types and helpers for the FPGA-to-Pi GPIO transmit path.
package raspi_gpio_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSetup   = 2'd1,
    StStrobe  = 2'd2,
    StRelease = 2'd3
  } tx_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned x;
    res = 0;
    x   = (value > 0) ? value - 1 : 0;
    while (x > 0) begin
      res++;
      x = x >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/raspi_tx_fifo.sv
// Synchronous FIFO buffering fabric bytes ahead of the GPIO handshake.
module raspi_tx_fifo import raspi_gpio_pkg::*; #(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              wr_data_i,
  input  logic                           wr_en_i,
  input  logic                           rd_en_i,
  output logic [DATA_W-1:0]              rd_data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [clog2(FIFO_DEPTH):0]     level_o
);

  localparam int unsigned AddrW = clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic              push, pop;

  assign full_o    = (level_q == LvlW'(FIFO_DEPTH));
  assign empty_o   = (level_q == '0);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/raspi_gpio_tx.sv
// FPGA-to-Pi byte transmitter: FIFO drained over a four-phase strobe/ack handshake.
module raspi_gpio_tx import raspi_gpio_pkg::*; #(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       wr_en_i,
  output logic                       full_o,
  output logic [clog2(FIFO_DEPTH):0] level_o,
  output logic [DATA_W-1:0]          raspi_data_o,
  output logic                       raspi_data_oe_o,
  output logic                       raspi_strb_o,
  input  logic                       raspi_ack_i,
  output logic                       busy_o,
  output logic                       sent_o,
  output logic                       timeout_o,
  input  logic                       clr_err_i
);

  localparam int unsigned CntMax = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC + 1;
  localparam int unsigned CntW   = clog2(CntMax) + 1;
  localparam logic [CntW-1:0] SetupLast   = CntW'(SETUP_CYC);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);

  tx_state_e         state_q;
  logic [CntW-1:0]   cnt_q, cnt_inc;
  logic              ack_meta_q, ack_s_q;
  logic [DATA_W-1:0] tx_q, fifo_rd_data;
  logic              fifo_empty, pop;
  logic              oe_q, strb_q, sent_q, timeout_q;

  raspi_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_data_i  (wr_data_i),
    .wr_en_i    (wr_en_i),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_rd_data),
    .full_o     (full_o),
    .empty_o    (fifo_empty),
    .level_o    (level_o)
  );

  // A high ack in IDLE means the Pi has not released the previous byte yet.
  assign pop     = (state_q == StIdle) && !fifo_empty && !ack_s_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      tx_q       <= '0;
      oe_q       <= 1'b0;
      strb_q     <= 1'b0;
      sent_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      ack_meta_q <= raspi_ack_i;
      ack_s_q    <= ack_meta_q;
      sent_q     <= 1'b0;
      cnt_q      <= cnt_inc;
      if (clr_err_i) begin
        timeout_q <= 1'b0;
      end
      // Later timeout assignments below override the clear in the same cycle.
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            tx_q    <= fifo_rd_data;
            cnt_q   <= '0;
            oe_q    <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == SetupLast) begin
            strb_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StStrobe;
          end
        end
        StStrobe: begin
          if (ack_s_q) begin
            strb_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= StRelease;
          end else if (cnt_q == TimeoutLast) begin
            timeout_q <= 1'b1;
            strb_q    <= 1'b0;
            oe_q      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StRelease: begin
          if (!ack_s_q) begin
            sent_q  <= 1'b1;
            oe_q    <= 1'b0;
            state_q <= StIdle;
          end else if (cnt_q == TimeoutLast) begin
            timeout_q <= 1'b1;
            oe_q      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign raspi_data_o    = tx_q;
  assign raspi_data_oe_o = oe_q;
  assign raspi_strb_o    = strb_q;
  assign busy_o          = (state_q != StIdle);
  assign sent_o          = sent_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_raspi_gpio_tx.sv
// Bench for raspi_gpio_tx: Pi handshake model plus a byte-stream reference queue.
module tb_raspi_gpio_tx;

  localparam int unsigned DataW      = 8;
  localparam int unsigned Depth      = 16;
  localparam int unsigned SetupCyc   = 4;
  localparam int unsigned TimeoutCyc = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DataW-1:0] wr_data_i = '0;
  logic             wr_en_i = 1'b0;
  logic             full_o;
  logic [4:0]       level_o;
  logic [DataW-1:0] raspi_data_o;
  logic             raspi_data_oe_o;
  logic             raspi_strb_o;
  logic             raspi_ack_i;
  logic             busy_o;
  logic             sent_o;
  logic             timeout_o;
  logic             clr_err_i = 1'b0;

  raspi_gpio_tx #(
    .DATA_W      (DataW),
    .FIFO_DEPTH  (Depth),
    .SETUP_CYC   (SetupCyc),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_data_i       (wr_data_i),
    .wr_en_i         (wr_en_i),
    .full_o          (full_o),
    .level_o         (level_o),
    .raspi_data_o    (raspi_data_o),
    .raspi_data_oe_o (raspi_data_oe_o),
    .raspi_strb_o    (raspi_strb_o),
    .raspi_ack_i     (raspi_ack_i),
    .busy_o          (busy_o),
    .sent_o          (sent_o),
    .timeout_o       (timeout_o),
    .clr_err_i       (clr_err_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Pi model: Normal mirrors strobe onto ack after a delay, Manual drives pi_force.
  typedef enum {PiNormal, PiManual} pi_mode_e;
  pi_mode_e pi_mode = PiManual;
  logic     pi_force = 1'b0;
  bit       pi_rand = 1'b0;
  int       pi_cnt = 0;
  int       pi_delay = 3;

  initial begin
    raspi_ack_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (pi_mode == PiManual) begin
        raspi_ack_i = pi_force;
        pi_cnt = 0;
      end else if (raspi_strb_o != raspi_ack_i) begin
        pi_cnt++;
        if (pi_cnt > pi_delay) begin
          raspi_ack_i = raspi_strb_o;
          pi_cnt = 0;
          pi_delay = pi_rand ? int'($urandom_range(4, 1)) : 3;
        end
      end else begin
        pi_cnt = 0;
      end
    end
  end

  // Reference: bytes the Pi should see, in order, derived from FIFO capacity alone.
  logic [DataW-1:0] rx_q[$];
  logic [DataW-1:0] exp_q[$];
  int   n_acc = 0;
  int   n_started = 0;
  int   n_sent = 0;
  int   stab_err = 0;
  logic oe_prev = 1'b0;
  logic [DataW-1:0] data_prev = '0;

  always @(posedge raspi_strb_o) rx_q.push_back(raspi_data_o);
  always @(posedge raspi_data_oe_o) n_started++;
  always @(posedge clk) if (sent_o) n_sent++;
  always @(negedge clk) begin
    if (raspi_data_oe_o && oe_prev && raspi_data_o !== data_prev) stab_err++;
    if (raspi_strb_o && !raspi_data_oe_o) stab_err++;
    oe_prev   = raspi_data_oe_o;
    data_prev = raspi_data_o;
  end

  task automatic push(input logic [DataW-1:0] b);
    bit acc;
    @(negedge clk);
    n_chk++;
    if (full_o !== ((n_acc - n_started) == int'(Depth))) begin
      n_err++;
      $display("FAIL push_full: full_o=%b required=%b", full_o, (n_acc - n_started) == int'(Depth));
    end
    n_chk++;
    if (level_o !== 5'(n_acc - n_started)) begin
      n_err++;
      $display("FAIL push_level: level_o=%0d required=%0d", level_o, n_acc - n_started);
    end
    acc = (n_acc - n_started) < int'(Depth);
    wr_data_i = b;
    wr_en_i   = 1'b1;
    @(posedge clk);
    #1 wr_en_i = 1'b0;
    if (acc) begin
      exp_q.push_back(b);
      n_acc++;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (level_o == 0 && !busy_o && !raspi_ack_i) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    n_chk++; if (full_o !== 1'b0) begin n_err++; $display("FAIL rst_full: got=%b want=0", full_o); end
    n_chk++; if (level_o !== 5'd0) begin n_err++; $display("FAIL rst_level: got=%0d want=0", level_o); end
    n_chk++; if (raspi_data_o !== 8'h00) begin n_err++; $display("FAIL rst_data: got=%h want=00", raspi_data_o); end
    n_chk++; if (raspi_data_oe_o !== 1'b0) begin n_err++; $display("FAIL rst_oe: got=%b want=0", raspi_data_oe_o); end
    n_chk++; if (raspi_strb_o !== 1'b0) begin n_err++; $display("FAIL rst_strb: got=%b want=0", raspi_strb_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got=%b want=0", busy_o); end
    n_chk++; if (sent_o !== 1'b0) begin n_err++; $display("FAIL rst_sent: got=%b want=0", sent_o); end
    n_chk++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got=%b want=0", timeout_o); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL idle_busy: got=%b want=0", busy_o); end
  endtask

  task automatic test_single;
    int c0, c1, s0, e0;
    bit ok;
    pi_mode = PiNormal; pi_rand = 1'b0; pi_delay = 3;
    rx_q.delete(); exp_q.delete();
    s0 = n_sent; e0 = stab_err; c0 = -1; c1 = -1;
    push(8'hA5);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (c0 < 0 && level_o == 0) c0 = cyc;
      if (raspi_strb_o) begin c1 = cyc; break; end
    end
    n_chk++;
    if (c0 < 0 || c1 < 0 || c1 - c0 != int'(SetupCyc) + 1) begin
      n_err++; $display("FAIL single_setup: pop_to_strb=%0d want=%0d", c1 - c0, SetupCyc + 1);
    end
    wait_idle(ok);
    n_chk++; if (!ok) begin n_err++; $display("FAIL single_drain: timed out"); end
    n_chk++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      n_err++; $display("FAIL single_data: n=%0d first=%h want=1 a5", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
    n_chk++; if (n_sent - s0 != 1) begin n_err++; $display("FAIL single_sent: got=%0d want=1", n_sent - s0); end
    n_chk++; if (level_o !== 5'd0) begin n_err++; $display("FAIL single_level: got=%0d want=0", level_o); end
    n_chk++; if (stab_err != e0) begin n_err++; $display("FAIL single_stable: errs=%0d want=0", stab_err - e0); end
  endtask

  task automatic test_burst;
    int s0, e0;
    bit ok;
    pi_mode = PiManual; pi_force = 1'b1;
    repeat (5) @(negedge clk);
    rx_q.delete(); exp_q.delete();
    s0 = n_sent; e0 = stab_err;
    for (int i = 0; i < 16; i++) push(8'(i));
    @(negedge clk);
    n_chk++; if (full_o !== 1'b1) begin n_err++; $display("FAIL burst_full: got=%b want=1", full_o); end
    push(8'hFF);
    @(negedge clk);
    n_chk++; if (level_o !== 5'd16) begin n_err++; $display("FAIL burst_drop: level=%0d want=16", level_o); end
    pi_rand = 1'b1; pi_mode = PiNormal;
    wait_idle(ok);
    n_chk++; if (!ok) begin n_err++; $display("FAIL burst_drain: timed out"); end
    n_chk++; if (rx_q.size() != 16) begin n_err++; $display("FAIL burst_count: got=%0d want=16", rx_q.size()); end
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[i] !== 8'(i)) begin n_err++; $display("FAIL burst_byte%0d: got=%h want=%h", i, rx_q[i], 8'(i)); end
    end
    n_chk++; if (n_sent - s0 != 16) begin n_err++; $display("FAIL burst_sent: got=%0d want=16", n_sent - s0); end
    n_chk++; if (stab_err != e0) begin n_err++; $display("FAIL burst_stable: errs=%0d want=0", stab_err - e0); end
  endtask

  task automatic test_timeout;
    int w, s0;
    bit ok;
    pi_mode = PiManual; pi_force = 1'b0;
    repeat (4) @(negedge clk);
    rx_q.delete(); exp_q.delete();
    s0 = n_sent;
    push(8'h3C);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (raspi_strb_o) break;
    end
    w = 0;
    for (int i = 0; i < 100; i++) begin
      if (!raspi_strb_o) break;
      w++;
      @(negedge clk);
    end
    n_chk++; if (w != int'(TimeoutCyc)) begin n_err++; $display("FAIL to_width: strb_cycles=%0d want=%0d", w, TimeoutCyc); end
    n_chk++; if (timeout_o !== 1'b1) begin n_err++; $display("FAIL to_flag: got=%b want=1", timeout_o); end
    n_chk++; if (busy_o !== 1'b0 || raspi_data_oe_o !== 1'b0) begin
      n_err++; $display("FAIL to_idle: busy=%b oe=%b want=0 0", busy_o, raspi_data_oe_o);
    end
    pi_mode = PiNormal; pi_rand = 1'b0;
    push(8'h4D);
    wait_idle(ok);
    n_chk++; if (!ok) begin n_err++; $display("FAIL to_drain: timed out"); end
    n_chk++;
    if (rx_q.size() != 2 || rx_q[rx_q.size()-1] !== 8'h4D) begin
      n_err++; $display("FAIL to_next: n=%0d want=2 with last 4d", rx_q.size());
    end
    n_chk++; if (n_sent - s0 != 1) begin n_err++; $display("FAIL to_sent: got=%0d want=1", n_sent - s0); end
    n_chk++; if (timeout_o !== 1'b1) begin n_err++; $display("FAIL to_sticky: got=%b want=1", timeout_o); end
    @(negedge clk); clr_err_i = 1'b1;
    @(negedge clk); clr_err_i = 1'b0;
    n_chk++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL to_clear: got=%b want=0", timeout_o); end
  endtask

  task automatic test_stuck_ack;
    int bad, c0, c1;
    bit ok;
    pi_mode = PiManual; pi_force = 1'b1;
    repeat (5) @(negedge clk);
    rx_q.delete(); exp_q.delete();
    push(8'h11);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy_o || raspi_data_oe_o) bad++;
    end
    n_chk++; if (bad != 0) begin n_err++; $display("FAIL stuck_hold: active_cycles=%0d want=0", bad); end
    n_chk++; if (level_o !== 5'd1) begin n_err++; $display("FAIL stuck_level: got=%0d want=1", level_o); end
    pi_force = 1'b0; c0 = -1; c1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c0 < 0 && !raspi_ack_i) c0 = cyc;
      if (raspi_data_oe_o) begin c1 = cyc; break; end
    end
    n_chk++; if (c0 < 0 || c1 < 0 || c1 - c0 > 3) begin n_err++; $display("FAIL stuck_start: delay=%0d want<=3", c1 - c0); end
    pi_mode = PiNormal;
    wait_idle(ok);
    n_chk++;
    if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'h11) begin
      n_err++; $display("FAIL stuck_data: ok=%b n=%0d want ok=1 n=1 byte 11", ok, rx_q.size());
    end
  endtask

  task automatic test_simul;
    bit ok;
    pi_mode = PiManual; pi_force = 1'b1;
    repeat (5) @(negedge clk);
    rx_q.delete(); exp_q.delete();
    push(8'h66);
    @(negedge clk);
    pi_force = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (level_o !== 5'd1 || raspi_data_oe_o !== 1'b0) begin
      n_err++; $display("FAIL simul_pre: level=%0d oe=%b want=1 0", level_o, raspi_data_oe_o);
    end
    push(8'h77);
    @(negedge clk);
    n_chk++; if (level_o !== 5'd1) begin n_err++; $display("FAIL simul_level: got=%0d want=1", level_o); end
    n_chk++; if (raspi_data_oe_o !== 1'b1) begin n_err++; $display("FAIL simul_pop: oe=%b want=1", raspi_data_oe_o); end
    pi_mode = PiNormal;
    wait_idle(ok);
    n_chk++;
    if (!ok || rx_q.size() != 2 || rx_q[0] !== 8'h66 || rx_q[1] !== 8'h77) begin
      n_err++; $display("FAIL simul_order: ok=%b n=%0d want ok=1 bytes 66 77", ok, rx_q.size());
    end
  endtask

  task automatic test_reset_mid;
    pi_mode = PiManual; pi_force = 1'b0;
    repeat (4) @(negedge clk);
    push(8'h5A);
    push(8'h5B);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (raspi_strb_o) break;
    end
    n_chk++; if (raspi_strb_o !== 1'b1) begin n_err++; $display("FAIL rmid_strb_seen: got=%b want=1", raspi_strb_o); end
    #1 rst = 1'b1;
    #1;
    n_chk++; if (raspi_strb_o !== 1'b0) begin n_err++; $display("FAIL rmid_strb: got=%b want=0", raspi_strb_o); end
    n_chk++; if (raspi_data_oe_o !== 1'b0) begin n_err++; $display("FAIL rmid_oe: got=%b want=0", raspi_data_oe_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got=%b want=0", busy_o); end
    n_chk++; if (level_o !== 5'd0) begin n_err++; $display("FAIL rmid_level: got=%0d want=0", level_o); end
    n_acc = 0; n_started = 0;
    rx_q.delete(); exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (busy_o !== 1'b0 || level_o !== 5'd0) begin
      n_err++; $display("FAIL rmid_after: busy=%b level=%0d want=0 0", busy_o, level_o);
    end
  endtask

  task automatic test_random;
    int s0, e0;
    bit ok;
    pi_mode = PiNormal; pi_rand = 1'b1;
    rx_q.delete(); exp_q.delete();
    s0 = n_sent; e0 = stab_err;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      push(8'($urandom));
    end
    wait_idle(ok);
    n_chk++; if (!ok) begin n_err++; $display("FAIL rand_drain: timed out"); end
    n_chk++; if (rx_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_count: got=%0d want=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_byte%0d: got=%h want=%h", i, rx_q[i], exp_q[i]); end
    end
    n_chk++; if (n_sent - s0 != exp_q.size()) begin
      n_err++; $display("FAIL rand_sent: got=%0d want=%0d", n_sent - s0, exp_q.size());
    end
    n_chk++; if (stab_err != e0) begin n_err++; $display("FAIL rand_stable: errs=%0d want=0", stab_err - e0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_timeout();
    test_stuck_ack();
    test_simul();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
